serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial unsigned adder, LSB first: the adding counterpart to the team's half subtractor.
- A full-adder cell (two half-adder stages plus a carry flip-flop) processes one operand bit per clock.
- Operands are loaded on a start handshake; a registered sum, carry-out and one-cycle done pulse are presented after WIDTH bit-cycles.
- Used as a compact arithmetic unit where area beats latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled on clk.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: sum/cout newly valid.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered carry-out of the MSB.
- sum_bit  output  1  serial sum bit of the current RUN cycle.
- sum_bit_vld  output  1  high when sum_bit is meaningful (RUN only).
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (rst_n low, any time, including mid-RUN):
  - State goes to IDLE immediately; the operation in progress is aborted.
  - busy, done, sum, cout, sum_bit, sum_bit_vld, ovf are all 0.
  - Operand shift registers, carry flip-flop and counter are cleared.
- IDLE:
  - start=1 at edge k: capture a and b into shift registers, clear carry and counter, go to RUN. busy=1 after edge k.
  - start=0: stay in IDLE.
- RUN, edges k+1 .. k+WIDTH:
  - Per edge: s = a_sh[0]^b_sh[0]^c; c <= (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0])).
  - Shift both operand registers right by one; shift s into the MSB of the internal sum register; counter += 1.
  - sum_bit is the combinational s of the current cycle; sum_bit_vld = busy.
  - After the edge at which the counter reaches WIDTH: go to DONE; copy internal sum to sum; copy c to cout.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - Next edge goes to IDLE, or directly to RUN if start=1 (back-to-back operation, new operands captured).
- start while busy is ignored: no operand capture, no restart, no error flag.
- Latency: start accepted at edge k gives done high in the cycle after edge k+WIDTH. That is WIDTH+1 cycles from accept to done, and a throughput of one addition per WIDTH+1 cycles.
- sum/cout are stable throughout RUN (they hold the previous result) and change only at the completion edge.
- Arithmetic: {cout,sum} = a + b, modulo 2^(WIDTH+1). No carry-in.
- WIDTH=1: one RUN cycle; {cout,sum} follows the half-adder truth table.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Port ovf exists.
  - At the completion edge, ovf <= (a_msb==b_msb) && (sum_msb != a_msb), using the MSBs captured at start.
  - ovf holds with sum and resets to 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, start pulse -> busy for 8 cycles, done one cycle later; sum=0x00, cout=0, sum_bit_vld high 8 cycles.
- WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, cout=1; serial sum_bit sequence 0,0,0,0,0,0,0,0. Also a=0x5A, b=0x33 -> sum=0x8D, cout=0.
- WIDTH=8 with SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- Start a=0x10, b=0x20; pulse start with a=0xFF, b=0xFF during cycle 3 of RUN -> ignored, result sum=0x30. Then assert start in the DONE cycle with a=0x01, b=0x02 -> next done after 9 cycles, sum=0x03.
- Drop rst_n low asynchronously at RUN cycle 4 -> all outputs 0 immediately, state IDLE. After release, a fresh start with a=0x03, b=0x04 -> sum=0x07.
- WIDTH=1: all four (a,b) pairs -> {cout,sum} = 00, 01, 01, 10; done 2 cycles after each accept.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and result bus of the bit-serial adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag to the bus.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             sum_bit;
    logic             sum_bit_vld;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout, sum_bit, sum_bit_vld, ovf
    );
    modport slave (
        input  start, a, b,
        output busy, done, sum, cout, sum_bit, sum_bit_vld, ovf
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, sum, cout, sum_bit, sum_bit_vld
    );
    modport slave (
        input  start, a, b,
        output busy, done, sum, cout, sum_bit, sum_bit_vld
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock (IDLE -> RUN -> DONE).
// Optional signed-overflow flag enabled by SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             half_s;
    logic             half_g;
    logic             s;
    logic             c_nxt;
    logic             last;
    logic             load;
    logic             busy_c;
    logic             done_c;

    // Full-adder cell built from two half-adder stages
    always_comb begin
        half_s = a_sh[0] ^ b_sh[0];
        half_g = a_sh[0] & b_sh[0];
        s      = half_s ^ c;
        c_nxt  = half_g | (half_s & c);
    end

    assign acc_nxt = (acc >> 1) | (WIDTH'(s) << (WIDTH - 1));
    assign cnt_nxt = cnt + CNT_W'(1);
    assign last    = (state == RUN) && (cnt_nxt == CNT_W'(WIDTH));
    assign load    = bus.start && (state != RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            RUN:     busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath: operand shifters, carry flop, bit counter, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            c    <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= acc_nxt;
            c    <= c_nxt;
            cnt  <= cnt_nxt;
            if (last) begin
                sum_q  <= acc_nxt;
                cout_q <= c_nxt;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    // Signed overflow: like-signed operands giving a differently-signed sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (load) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (last) begin
            ovf_q <= (a_msb == b_msb) && (acc_nxt[WIDTH-1] != a_msb);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.sum         = sum_q;
    assign bus.cout        = cout_q;
    assign bus.sum_bit     = busy_c & s;
    assign bus.sum_bit_vld = busy_c;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances, random ops vs. a + b model.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Drives one WIDTH=8 addition from the current negedge and records what the DUT shows.
    // A nonzero glitch_at pulses start with 0xFF/0xFF in that RUN cycle.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input int glitch_at,
                           output logic [8:0] res, output logic [7:0] bits, output int vcnt,
                           output int lat, output logic ovf_o, output logic held);
        logic [7:0] sum0;
        sum0  = bus8.sum;
        held  = 1'b1;
        bits  = '0;
        vcnt  = 0;
        lat   = 0;
        res   = '0;
        ovf_o = 1'b0;
        bus8.a     = av;
        bus8.b     = bv;
        bus8.start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1 || n == glitch_at + 1) bus8.start = 1'b0;
            if (n == glitch_at) begin
                bus8.start = 1'b1;
                bus8.a     = 8'hFF;
                bus8.b     = 8'hFF;
            end
            if (bus8.sum_bit_vld) begin
                if (vcnt < 8) bits[vcnt] = bus8.sum_bit;
                vcnt++;
            end
            if (bus8.busy && bus8.sum !== sum0) held = 1'b0;
            if (bus8.done) begin
                lat = n;
                res = {bus8.cout, bus8.sum};
`ifdef SERIAL_ADDER_OVF_EN
                ovf_o = bus8.ovf;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.sum_bit, bus8.sum_bit_vld} !== 13'h0) begin
            bad++;
            $display("FAIL reset_w8 got=%h exp=0", {bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.sum_bit, bus8.sum_bit_vld});
        end
        total++;
        if ({bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.sum_bit, bus1.sum_bit_vld} !== 6'h0) begin
            bad++;
            $display("FAIL reset_w1 got=%h exp=0", {bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.sum_bit, bus1.sum_bit_vld});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Directed patterns, each started from IDLE, with done checked to be a single cycle
    task automatic test_basic();
        logic [7:0] ta [3] = '{8'h00, 8'hFF, 8'h5A};
        logic [7:0] tb [3] = '{8'h00, 8'h01, 8'h33};
        logic [8:0] res, exp;
        logic [7:0] bits;
        int vcnt, lat;
        logic ovf_o, held;
        for (int i = 0; i < 3; i++) begin
            exp = 9'(ta[i]) + 9'(tb[i]);
            run_op8(ta[i], tb[i], 0, res, bits, vcnt, lat, ovf_o, held);
            total++;
            if (res !== exp) begin bad++; $display("FAIL basic_sum[%0d] got=%h exp=%h", i, res, exp); end
            total++;
            if (bits !== exp[7:0]) begin bad++; $display("FAIL basic_bits[%0d] got=%b exp=%b", i, bits, exp[7:0]); end
            total++;
            if (lat !== 9 || vcnt !== 8) begin bad++; $display("FAIL basic_timing[%0d] lat=%0d vld=%0d exp 9/8", i, lat, vcnt); end
            @(negedge clk);
            total++;
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.sum !== exp[7:0]) begin
                bad++;
                $display("FAIL basic_after[%0d] done=%b busy=%b sum=%h exp 0/0/%h", i, bus8.done, bus8.busy, bus8.sum, exp[7:0]);
            end
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] ta [2] = '{8'h7F, 8'h80};
        logic [7:0] tb [2] = '{8'h01, 8'h80};
        logic [8:0] res, exp;
        logic [7:0] bits;
        int vcnt, lat;
        logic ovf_o, held, oexp;
        for (int i = 0; i < 2; i++) begin
            exp  = 9'(ta[i]) + 9'(tb[i]);
            oexp = (ta[i][7] == tb[i][7]) && (exp[7] != ta[i][7]);
            run_op8(ta[i], tb[i], 0, res, bits, vcnt, lat, ovf_o, held);
            total++;
            if (res !== exp || ovf_o !== oexp) begin
                bad++;
                $display("FAIL ovf[%0d] got=%h/%b exp=%h/%b", i, res, ovf_o, exp, oexp);
            end
            @(negedge clk);
        end
    endtask
`endif

    // start mid-RUN is ignored; start in the DONE cycle launches the next add
    task automatic test_back_to_back();
        logic [8:0] res;
        logic [7:0] bits;
        int vcnt, lat;
        logic ovf_o, held;
        run_op8(8'h10, 8'h20, 3, res, bits, vcnt, lat, ovf_o, held);
        total++;
        if (res !== 9'h030 || lat !== 9) begin bad++; $display("FAIL ignore_start got=%h lat=%0d exp=030 lat=9", res, lat); end
        run_op8(8'h01, 8'h02, 0, res, bits, vcnt, lat, ovf_o, held);
        total++;
        if (res !== 9'h003 || lat !== 9) begin bad++; $display("FAIL b2b got=%h lat=%0d exp=003 lat=9", res, lat); end
        total++;
        if (held !== 1'b1) begin bad++; $display("FAIL b2b_sum_held got=%b exp=1", held); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [8:0] res;
        logic [7:0] bits;
        int vcnt, lat;
        logic ovf_o, held;
        bus8.a = 8'h55; bus8.b = 8'h0F; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus8.busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy got=%b exp=1", bus8.busy); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.sum_bit, bus8.sum_bit_vld} !== 13'h0) begin
            bad++;
            $display("FAIL arst_outputs got=%h exp=0", {bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.sum_bit, bus8.sum_bit_vld});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus8.busy !== 1'b0) begin bad++; $display("FAIL arst_idle busy=%b exp=0", bus8.busy); end
        run_op8(8'h03, 8'h04, 0, res, bits, vcnt, lat, ovf_o, held);
        total++;
        if (res !== 9'h007) begin bad++; $display("FAIL arst_fresh got=%h exp=007", res); end
        @(negedge clk);
    endtask

    task automatic test_width1();
        logic [1:0] exp;
        int lat;
        logic bit0;
        for (int i = 0; i < 4; i++) begin
            logic av, bv;
            av  = 1'(i >> 1);
            bv  = 1'(i);
            exp = 2'(av) + 2'(bv);
            lat = 0;
            bit0 = 1'b0;
            bus1.a = av; bus1.b = bv; bus1.start = 1'b1;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    bus1.start = 1'b0;
                    bit0 = bus1.sum_bit;
                end
                if (bus1.done) begin lat = n; break; end
            end
            total++;
            if ({bus1.cout, bus1.sum} !== exp || lat !== 2 || bit0 !== exp[0]) begin
                bad++;
                $display("FAIL w1[%0d] got=%b lat=%0d bit=%b exp=%b lat=2 bit=%b", i, {bus1.cout, bus1.sum}, lat, bit0, exp, exp[0]);
            end
            @(negedge clk);
        end
    endtask

    // Random operands, random idle gaps and stray starts during RUN
    task automatic test_random();
        logic [8:0] res, exp;
        logic [7:0] bits, av, bv;
        int vcnt, lat, nbad;
        logic ovf_o, held, oexp;
        nbad = 0;
        for (int i = 0; i < 24; i++) begin
            av   = 8'($urandom);
            bv   = 8'($urandom);
            exp  = 9'(av) + 9'(bv);
            oexp = (av[7] == bv[7]) && (exp[7] != av[7]);
            run_op8(av, bv, int'($urandom_range(0, 8)), res, bits, vcnt, lat, ovf_o, held);
            total++;
            if (res !== exp || bits !== exp[7:0] || lat !== 9 || vcnt !== 8 || held !== 1'b1) begin
                bad++;
                $display("FAIL rand[%0d] a=%h b=%h got=%h bits=%h lat=%0d vld=%0d held=%b exp=%h", i, av, bv, res, bits, lat, vcnt, held, exp);
            end
`ifdef SERIAL_ADDER_OVF_EN
            total++;
            if (ovf_o !== oexp) begin bad++; $display("FAIL rand_ovf[%0d] got=%b exp=%b", i, ovf_o, oexp); end
`endif
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        test_reset();
        test_basic();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_async_reset();
        test_width1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
